// File: rtl/rf_seq_pkg.sv
// rtl/rf_seq_pkg.sv - shared opcodes, state encoding and widths for rf_alu_sequencer
package rf_seq_pkg;

    localparam int OP_W  = 3;
    localparam int ST_W  = 2;
    localparam int CNT_W = 32;

    localparam logic [OP_W-1:0] OP_AND = 3'b000;
    localparam logic [OP_W-1:0] OP_OR  = 3'b001;
    localparam logic [OP_W-1:0] OP_ADD = 3'b010;
    localparam logic [OP_W-1:0] OP_SUB = 3'b110;
    localparam logic [OP_W-1:0] OP_SLT = 3'b111;

    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_READ = 2'd1;
    localparam logic [ST_W-1:0] ST_EXEC = 2'd2;
    localparam logic [ST_W-1:0] ST_WB   = 2'd3;

    function automatic logic op_legal(input logic [OP_W-1:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: op_legal = 1'b1;
            default:                               op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rf_seq_fsm.sv
// rtl/rf_seq_fsm.sv - IDLE/READ/EXEC/WB sequencing, command acceptance and completion strobe
module rf_seq_fsm
    import rf_seq_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    output logic            accept,
    output logic [ST_W-1:0] state,
    output logic            done_valid
);

    logic [ST_W-1:0] state_q;
    logic [ST_W-1:0] state_d;

    always_comb begin
        cmd_ready  = (state_q == ST_IDLE);
        accept     = cmd_ready && cmd_valid;
        done_valid = (state_q == ST_WB);
        state      = state_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_READ;
            ST_READ: state_d = ST_EXEC;
            ST_EXEC: state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/rf_alu_sequencer.sv
// rtl/rf_alu_sequencer.sv - multi-cycle controller driving register file and ALU for one command at a time
module rf_alu_sequencer
    import rf_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int IMM_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_rd,
    input  logic [ADDR_WIDTH-1:0] cmd_rs,
    input  logic [ADDR_WIDTH-1:0] cmd_rt,
    input  logic                  cmd_use_imm,
    input  logic [IMM_WIDTH-1:0]  cmd_imm,
    output logic [ADDR_WIDTH-1:0] rf_raddr1,
    output logic [ADDR_WIDTH-1:0] rf_raddr2,
    input  logic [DATA_WIDTH-1:0] rf_rdata1,
    input  logic [DATA_WIDTH-1:0] rf_rdata2,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic                  rf_wen,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [2:0]            alu_op,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_zero,
    input  logic                  alu_overflow,
    output logic                  done_valid,
    output logic                  done_err,
    output logic [DATA_WIDTH-1:0] done_result,
    output logic                  done_zero,
    output logic                  done_overflow,
    output logic [31:0]           retired_cnt
);

    logic            accept;
    logic [ST_W-1:0] state;

    rf_seq_fsm u_fsm (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .accept     (accept),
        .state      (state),
        .done_valid (done_valid)
    );

    logic [OP_W-1:0]       op_q, op_d;
    logic [ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [ADDR_WIDTH-1:0] rs_q, rs_d;
    logic [ADDR_WIDTH-1:0] rt_q, rt_d;
    logic                  use_imm_q, use_imm_d;
    logic [IMM_WIDTH-1:0]  imm_q, imm_d;
    logic [DATA_WIDTH-1:0] opa_q, opa_d;
    logic [DATA_WIDTH-1:0] opb_q, opb_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  zero_q, zero_d;
    logic                  ovf_q, ovf_d;
    logic [CNT_W-1:0]      retired_q, retired_d;

    logic [DATA_WIDTH-1:0] imm_ext;
    logic                  legal;

    always_comb begin
        imm_ext = {{(DATA_WIDTH-IMM_WIDTH){imm_q[IMM_WIDTH-1]}}, imm_q};
        legal   = op_legal(op_q);
    end

    always_comb begin
        op_d      = op_q;
        rd_d      = rd_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        use_imm_d = use_imm_q;
        imm_d     = imm_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        result_d  = result_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        retired_d = retired_q;
        if (accept) begin
            op_d      = cmd_op;
            rd_d      = cmd_rd;
            rs_d      = cmd_rs;
            rt_d      = cmd_rt;
            use_imm_d = cmd_use_imm;
            imm_d     = cmd_imm;
        end
        if (state == ST_READ) begin
            opa_d = rf_rdata1;
            opb_d = use_imm_q ? imm_ext : rf_rdata2;
        end
        if (state == ST_EXEC) begin
            result_d = alu_result;
            zero_d   = alu_zero;
            ovf_d    = alu_overflow;
        end
        if (state == ST_WB) begin
            retired_d = retired_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= '0;
            rd_q      <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            use_imm_q <= 1'b0;
            imm_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            retired_q <= '0;
        end else begin
            op_q      <= op_d;
            rd_q      <= rd_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            use_imm_q <= use_imm_d;
            imm_q     <= imm_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            ovf_q     <= ovf_d;
            retired_q <= retired_d;
        end
    end

    // Bus outputs are zero outside the state that owns them so the RF/ALU see a quiet interface.
    always_comb begin
        rf_raddr1 = '0;
        rf_raddr2 = '0;
        alu_a     = '0;
        alu_b     = '0;
        alu_op    = '0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        rf_wen    = 1'b0;
        done_err  = 1'b0;
        case (state)
            ST_READ: begin
                rf_raddr1 = rs_q;
                rf_raddr2 = rt_q;
            end
            ST_EXEC: begin
                alu_a  = opa_q;
                alu_b  = opb_q;
                alu_op = legal ? op_q : OP_ADD;
            end
            ST_WB: begin
                rf_waddr = rd_q;
                rf_wdata = result_q;
                rf_wen   = legal && (rd_q != '0);
                done_err = !legal;
            end
            default: ;
        endcase
    end

    always_comb begin
        done_result   = result_q;
        done_zero     = zero_q;
        done_overflow = ovf_q;
        retired_cnt   = retired_q;
    end

endmodule

// File: tb/tb_rf_alu_sequencer.sv
// tb/tb_rf_alu_sequencer.sv - directed bench with register file and ALU models around rf_alu_sequencer
module tb_rf_alu_sequencer;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [4:0]  cmd_rd;
    logic [4:0]  cmd_rs;
    logic [4:0]  cmd_rt;
    logic        cmd_use_imm;
    logic [15:0] cmd_imm;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic [4:0]  rf_waddr;
    logic        rf_wen;
    logic [31:0] rf_wdata;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_overflow;
    logic        done_valid;
    logic        done_err;
    logic [31:0] done_result;
    logic        done_zero;
    logic        done_overflow;
    logic [31:0] retired_cnt;

    rf_alu_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_rd        (cmd_rd),
        .cmd_rs        (cmd_rs),
        .cmd_rt        (cmd_rt),
        .cmd_use_imm   (cmd_use_imm),
        .cmd_imm       (cmd_imm),
        .rf_raddr1     (rf_raddr1),
        .rf_raddr2     (rf_raddr2),
        .rf_rdata1     (rf_rdata1),
        .rf_rdata2     (rf_rdata2),
        .rf_waddr      (rf_waddr),
        .rf_wen        (rf_wen),
        .rf_wdata      (rf_wdata),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_op        (alu_op),
        .alu_result    (alu_result),
        .alu_zero      (alu_zero),
        .alu_overflow  (alu_overflow),
        .done_valid    (done_valid),
        .done_err      (done_err),
        .done_result   (done_result),
        .done_zero     (done_zero),
        .done_overflow (done_overflow),
        .retired_cnt   (retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] regs [32];
    int          cyc;
    int          wen_cnt;
    int          done_cnt;
    int          acc_q[$];
    int          checks;
    int          errors;
    int          exp_ret;

    assign rf_rdata1 = (rf_raddr1 == 5'd0) ? 32'd0 : regs[rf_raddr1];
    assign rf_rdata2 = (rf_raddr2 == 5'd0) ? 32'd0 : regs[rf_raddr2];

    always_comb begin
        alu_result   = 32'd0;
        alu_overflow = 1'b0;
        case (alu_op)
            3'b000: alu_result = alu_a & alu_b;
            3'b001: alu_result = alu_a | alu_b;
            3'b010: begin
                alu_result   = alu_a + alu_b;
                alu_overflow = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
            end
            3'b110: begin
                alu_result   = alu_a - alu_b;
                alu_overflow = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
            end
            3'b111: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_result = 32'd0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rf_wen) begin
            regs[rf_waddr] <= rf_wdata;
            wen_cnt <= wen_cnt + 1;
        end
        if (done_valid) done_cnt <= done_cnt + 1;
        if (cmd_valid && cmd_ready && !rst) acc_q.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called and returns on a falling edge; checks every phase of one command.
    task automatic run_cmd(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs,
                           input logic [4:0] rt, input logic use_imm, input logic [15:0] imm,
                           input logic [31:0] exp_a, input logic [31:0] exp_b, input logic [2:0] exp_aop,
                           input logic exp_wen, input logic [31:0] exp_res, input logic exp_zero,
                           input logic exp_ovf, input logic exp_err);
        chk("ready_idle", 32'(cmd_ready), 32'd1);
        cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_rt = rt;
        cmd_use_imm = use_imm; cmd_imm = imm; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("read_ready", 32'(cmd_ready), 32'd0);
        chk("read_raddr1", 32'(rf_raddr1), 32'(rs));
        chk("read_raddr2", 32'(rf_raddr2), 32'(rt));
        @(negedge clk);
        chk("exec_a", alu_a, exp_a);
        chk("exec_b", alu_b, exp_b);
        chk("exec_op", 32'(alu_op), 32'(exp_aop));
        chk("exec_raddr1", 32'(rf_raddr1), 32'd0);
        @(negedge clk);
        chk("wb_wen", 32'(rf_wen), 32'(exp_wen));
        chk("wb_waddr", 32'(rf_waddr), 32'(rd));
        chk("wb_wdata", rf_wdata, exp_res);
        chk("wb_done", 32'(done_valid), 32'd1);
        chk("wb_err", 32'(done_err), 32'(exp_err));
        chk("wb_result", done_result, exp_res);
        chk("wb_zero", 32'(done_zero), 32'(exp_zero));
        chk("wb_ovf", 32'(done_overflow), 32'(exp_ovf));
        chk("wb_alu_a", alu_a, 32'd0);
        @(negedge clk);
        exp_ret++;
        chk("post_ready", 32'(cmd_ready), 32'd1);
        chk("post_done", 32'(done_valid), 32'd0);
        chk("post_wen", 32'(rf_wen), 32'd0);
        chk("post_retired", retired_cnt, 32'(exp_ret));
        chk("post_hold_result", done_result, exp_res);
    endtask

    initial begin
        int wen_snap;
        int done_snap;
        checks = 0; errors = 0; exp_ret = 0;
        cyc = 0; wen_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_rd = 5'd0; cmd_rs = 5'd0;
        cmd_rt = 5'd0; cmd_use_imm = 1'b0; cmd_imm = 16'd0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_done", 32'(done_valid), 32'd0);
        chk("rst_wen", 32'(rf_wen), 32'd0);
        chk("rst_retired", retired_cnt, 32'd0);
        chk("rst_result", done_result, 32'd0);
        rst = 1'b0;

        //      op      rd     rs     rt     imm   immv      a            b            aop     wen   res           z     o     err
        run_cmd(3'b010, 5'd1, 5'd0, 5'd0, 1'b1, 16'd5,   32'd0,       32'd5,       3'b010, 1'b1, 32'd5,        1'b0, 1'b0, 1'b0);
        run_cmd(3'b010, 5'd2, 5'd0, 5'd0, 1'b1, 16'd7,   32'd0,       32'd7,       3'b010, 1'b1, 32'd7,        1'b0, 1'b0, 1'b0);
        run_cmd(3'b110, 5'd3, 5'd1, 5'd2, 1'b0, 16'd0,   32'd5,       32'd7,       3'b110, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
        run_cmd(3'b111, 5'd4, 5'd1, 5'd2, 1'b0, 16'd0,   32'd5,       32'd7,       3'b111, 1'b1, 32'd1,        1'b0, 1'b0, 1'b0);
        regs[6] = 32'h7FFFFFFF;
        run_cmd(3'b010, 5'd5, 5'd6, 5'd6, 1'b0, 16'd0,   32'h7FFFFFFF, 32'h7FFFFFFF, 3'b010, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0);
        run_cmd(3'b010, 5'd0, 5'd1, 5'd0, 1'b1, 16'd1,   32'd5,       32'd1,       3'b010, 1'b0, 32'd6,        1'b0, 1'b0, 1'b0);
        run_cmd(3'b011, 5'd7, 5'd1, 5'd2, 1'b0, 16'd0,   32'd5,       32'd7,       3'b010, 1'b0, 32'd12,       1'b0, 1'b0, 1'b1);
        chk("err_no_write", regs[7], 32'd0);
        run_cmd(3'b001, 5'd7, 5'd1, 5'd2, 1'b0, 16'd0,   32'd5,       32'd7,       3'b001, 1'b1, 32'd7,        1'b0, 1'b0, 1'b0);
        run_cmd(3'b000, 5'd8, 5'd1, 5'd0, 1'b1, 16'hFFFC, 32'd5,      32'hFFFFFFFC, 3'b000, 1'b1, 32'd4,       1'b0, 1'b0, 1'b0);
        run_cmd(3'b010, 5'd1, 5'd1, 5'd0, 1'b1, 16'd1,   32'd5,       32'd1,       3'b010, 1'b1, 32'd6,        1'b0, 1'b0, 1'b0);
        run_cmd(3'b110, 5'd9, 5'd2, 5'd2, 1'b0, 16'd0,   32'd7,       32'd7,       3'b110, 1'b1, 32'd0,        1'b1, 1'b0, 1'b0);
        chk("r1_updated", regs[1], 32'd6);
        chk("r7_or", regs[7], 32'd7);
        chk("r0_untouched", regs[0], 32'd0);

        // Back-to-back with cmd_valid held high; each command depends on its predecessor.
        acc_q.delete();
        cmd_valid = 1'b1;
        cmd_op = 3'b010; cmd_rd = 5'd10; cmd_rs = 5'd0; cmd_rt = 5'd0; cmd_use_imm = 1'b1; cmd_imm = 16'd3;
        for (int i = 0; i < 3; i++) begin
            for (int w = 0; w < 10 && acc_q.size() <= i; w++) @(negedge clk);
            chk("b2b_accept", 32'(acc_q.size()), 32'(i + 1));
            if (i == 0) begin
                cmd_rd = 5'd11; cmd_rs = 5'd10; cmd_imm = 16'd4;
            end else if (i == 1) begin
                cmd_rd = 5'd12; cmd_rs = 5'd11; cmd_rt = 5'd10; cmd_use_imm = 1'b0;
            end else begin
                cmd_valid = 1'b0;
            end
        end
        repeat (5) @(negedge clk);
        exp_ret += 3;
        if (acc_q.size() == 3) begin
            chk("b2b_gap1", 32'(acc_q[1] - acc_q[0]), 32'd4);
            chk("b2b_gap2", 32'(acc_q[2] - acc_q[0]), 32'd8);
        end else begin
            chk("b2b_count", 32'(acc_q.size()), 32'd3);
        end
        chk("b2b_r10", regs[10], 32'd3);
        chk("b2b_r11", regs[11], 32'd7);
        chk("b2b_r12", regs[12], 32'd10);
        chk("b2b_retired", retired_cnt, 32'(exp_ret));

        // Reset while the command is in EXEC drops it entirely.
        cmd_op = 3'b010; cmd_rd = 5'd13; cmd_rs = 5'd0; cmd_rt = 5'd0; cmd_use_imm = 1'b1; cmd_imm = 16'd9;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("mid_exec_a", alu_a, 32'd0);
        chk("mid_exec_b", alu_b, 32'd9);
        wen_snap = wen_cnt;
        done_snap = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_retired", retired_cnt, 32'd0);
        chk("mrst_result", done_result, 32'd0);
        chk("mrst_ready", 32'(cmd_ready), 32'd1);
        chk("mrst_wen", 32'(rf_wen), 32'd0);
        repeat (4) @(negedge clk);
        chk("mrst_no_wen", 32'(wen_cnt), 32'(wen_snap));
        chk("mrst_no_done", 32'(done_cnt), 32'(done_snap));
        chk("mrst_r13", regs[13], 32'd0);
        chk("mrst_ready_late", 32'(cmd_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_alu_sequencer.md
Name: rf_alu_sequencer

Overview:
Multi-cycle controller that executes one register-to-register or register-immediate ALU command at a time. It accepts a command over a valid/ready handshake and reads source operands through the register-file read ports. It then drives the ALU, writes the result back through the register-file write port, and reports completion. It sits between a command source (bench or future fetch/decode stage) and the register file / ALU pair, and is the only master of both.

Parameters:
DATA_WIDTH, 32, register and ALU data width
ADDR_WIDTH, 5, register address width
IMM_WIDTH, 16, immediate width; sign-extended to DATA_WIDTH

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command
cmd_op  in  3  ALU operation code
cmd_rd  in  ADDR_WIDTH  destination register
cmd_rs  in  ADDR_WIDTH  source 1
cmd_rt  in  ADDR_WIDTH  source 2; ignored when cmd_use_imm=1
cmd_use_imm  in  1  operand B = sign-extended cmd_imm
cmd_imm  in  IMM_WIDTH  immediate
rf_raddr1  out  ADDR_WIDTH  to register file read port 1
rf_raddr2  out  ADDR_WIDTH  to register file read port 2
rf_rdata1  in  DATA_WIDTH  combinational read data 1
rf_rdata2  in  DATA_WIDTH  combinational read data 2
rf_waddr  out  ADDR_WIDTH  write address
rf_wen  out  1  write enable
rf_wdata  out  DATA_WIDTH  write data
alu_a  out  DATA_WIDTH  ALU operand A
alu_b  out  DATA_WIDTH  ALU operand B
alu_op  out  3  ALU operation
alu_result  in  DATA_WIDTH  combinational ALU result
alu_zero  in  1  ALU zero flag
alu_overflow  in  1  ALU overflow flag
done_valid  out  1  one-cycle completion pulse
done_err  out  1  qualifies done_valid: illegal opcode, no writeback
done_result  out  DATA_WIDTH  result of completed command
done_zero  out  1  zero flag of completed command
done_overflow  out  1  overflow flag of completed command
retired_cnt  out  32  count of completed commands, including errors

Behaviour:
- FSM states: IDLE, READ, EXEC, WB. Transitions: IDLE->READ on cmd_valid&&cmd_ready; READ->EXEC; EXEC->WB; WB->IDLE. All are unconditional except the transition out of IDLE.
- cmd_ready=1 only in IDLE. All cmd_* fields are latched on the handshake cycle.
- Latency: handshake at edge T. READ runs in cycle T+1, EXEC in T+2, WB in T+3, and IDLE (ready) in T+4. Throughput is 1 command per 4 cycles. cmd_valid held high gives back-to-back accepts every 4 cycles.
- READ: rf_raddr1=rs_q, rf_raddr2=rt_q. Operand A is latched from rf_rdata1. Operand B is latched from rf_rdata2, or from sign-extended imm_q if use_imm_q.
- EXEC: alu_a/alu_b are driven from the operand registers and alu_op=op_q. alu_result, alu_zero and alu_overflow are latched at the end of the cycle.
- WB: rf_waddr=rd_q and rf_wdata=result_q. rf_wen=1 iff op legal and rd_q!=0. done_valid=1 with done_* = latched values.
- Outside their active states: rf_raddr*=0, alu_a/alu_b=0, alu_op=0, rf_wen=0, done_valid=0. done_result/zero/overflow hold their last values.
- Legal opcodes: AND=000, OR=001, ADD=010, SUB=110, SLT=111.
- Any other opcode still walks READ/EXEC/WB. In that case alu_op is forced to ADD, rf_wen=0, and done_err=1.
- rd=0: no write (rf_wen=0), done_valid still pulses, done_err=0.
- rs==rd or rt==rd: the sources are read in READ before the WB of the same command, so the old value is used.
- Consecutive commands: the next READ follows the previous WB edge, so it sees the updated value. No forwarding is needed.
- retired_cnt: increments by 1 in every WB cycle and wraps at 2^32-1 -> 0.
- Reset: all outputs go to 0 and state goes to IDLE (cmd_ready=1 in the first cycle after reset deasserts).
- Reset mid-operation: the in-flight command is dropped with no rf_wen and no done_valid. retired_cnt=0.
- cmd_valid while not ready is ignored. The source must hold it.

Decomposition:
- Package rf_seq_pkg holds:
  - ALU opcode constants: AND, OR, ADD, SUB, SLT.
  - FSM state encoding: 2-bit enum IDLE/READ/EXEC/WB.
  - Width constants.
- Sub-module: one natural split, rf_seq_fsm, containing state register, next-state logic and cmd_ready/done_valid generation. The operand/result datapath registers stay in the top.

Test Plan:
- Reset, then ADD rd=1 rs=0 imm=5 use_imm -> rf_wen at T+3 with waddr=1, wdata=5. done_valid pulse with done_result=5, cmd_ready back high at T+4.
- r1=5, r2=7 preloaded via immediates; SUB rd=3 rs=1 rt=2 -> wdata=0xFFFFFFFE, done_zero=0. SLT rd=4 rs=1 rt=2 -> wdata=1.
- ADD rd=5 rs=r6 rt=r6 with r6=0x7FFFFFFF -> wdata=0xFFFFFFFE, done_overflow=1. Then ADD rd=0 rs=1 imm=1 -> rf_wen=0, done_valid=1, done_err=0.
- cmd_op=011 -> no rf_wen, done_err=1, retired_cnt still increments. A following legal command executes normally.
- cmd_valid held high for 3 commands -> accepts at cycles 0, 4, 8. A command reading rd of its predecessor sees the new value.
- Assert rst during EXEC -> no rf_wen, no done_valid, retired_cnt=0, and cmd_ready=1 the cycle after rst drops.
